// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - FIFO command encodings and controller state encoding
package fifo_ctrl_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PUSH = 2'b01;
  localparam logic [1:0] MODE_POP  = 2'b10;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot round-robin pick, search starts just after ptr
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (en_i && !found && req_i[i] && (i == (int'(ptr_i) + k) % NREQ)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - shares one mode-driven FIFO among NREQ producers and NREQ consumers
module fifo_access_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int DW    = 4,
  parameter  int DEPTH = 5,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  push_req_i,
  input  logic [NREQ*DW-1:0] push_data_i,
  output logic [NREQ-1:0]  push_gnt_o,
  input  logic [NREQ-1:0]  pop_req_i,
  output logic [NREQ-1:0]  pop_gnt_o,
  output logic [NREQ-1:0]  rd_valid_o,
  output logic [DW-1:0]    rd_data_o,
  input  logic             flush_i,
  output logic             flush_done_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       fifo_mode_o,
  output logic [DW-1:0]    fifo_datain_o,
  input  logic [DW-1:0]    fifo_dataout_i
);

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   push_ptr_q, push_ptr_d;
  logic [PW-1:0]   pop_ptr_q, pop_ptr_d;
  logic            prio_pop_q, prio_pop_d;
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   datain_q, datain_d;
  logic [NREQ-1:0] s1_q, s1_d;
  logic [NREQ-1:0] s2_q, s2_d;
  logic            flush_done_q, flush_done_d;

  logic run_ok, any_push, any_pop, push_en, pop_en, push_vld, pop_vld;

  // Decisions use the committed count only, never the FIFO's own flags.
  assign run_ok   = (state_q == ST_RUN) && !flush_i;
  assign any_push = (count_q < CW'(DEPTH)) && (|push_req_i);
  assign any_pop  = (count_q != '0) && (|pop_req_i);
  assign push_en  = run_ok && any_push && (!any_pop || !prio_pop_q);
  assign pop_en   = run_ok && any_pop && (!any_push || prio_pop_q);

  rr_arbiter #(.NREQ(NREQ)) u_push_arb (
    .req_i   (push_req_i),
    .en_i    (push_en),
    .ptr_i   (push_ptr_q),
    .gnt_o   (push_gnt_o),
    .valid_o (push_vld)
  );

  rr_arbiter #(.NREQ(NREQ)) u_pop_arb (
    .req_i   (pop_req_i),
    .en_i    (pop_en),
    .ptr_i   (pop_ptr_q),
    .gnt_o   (pop_gnt_o),
    .valid_o (pop_vld)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    push_ptr_d   = push_ptr_q;
    pop_ptr_d    = pop_ptr_q;
    prio_pop_d   = prio_pop_q;
    mode_d       = MODE_IDLE;
    datain_d     = datain_q;
    s1_d         = '0;
    s2_d         = s1_q;
    flush_done_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (flush_i) begin
        state_d = ST_FLUSH;
      end else if (push_vld) begin
        mode_d     = MODE_PUSH;
        count_d    = count_q + CW'(1);
        prio_pop_d = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (push_gnt_o[i]) begin
            datain_d   = push_data_i[i*DW +: DW];
            push_ptr_d = PW'(i);
          end
        end
      end else if (pop_vld) begin
        mode_d     = MODE_POP;
        count_d    = count_q - CW'(1);
        prio_pop_d = 1'b0;
        s1_d       = pop_gnt_o;
        for (int i = 0; i < NREQ; i++) begin
          if (pop_gnt_o[i]) pop_ptr_d = PW'(i);
        end
      end
    end else begin
      // Drain pops leave s1_d empty so they never reach a consumer.
      if (count_q != '0) begin
        mode_d  = MODE_POP;
        count_d = count_q - CW'(1);
      end else begin
        flush_done_d = 1'b1;
        state_d      = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      count_q      <= '0;
      push_ptr_q   <= '0;
      pop_ptr_q    <= '0;
      prio_pop_q   <= 1'b0;
      mode_q       <= MODE_IDLE;
      datain_q     <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      push_ptr_q   <= push_ptr_d;
      pop_ptr_q    <= pop_ptr_d;
      prio_pop_q   <= prio_pop_d;
      mode_q       <= mode_d;
      datain_q     <= datain_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign count_o       = count_q;
  assign full_o        = (count_q == CW'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign fifo_mode_o   = mode_q;
  assign fifo_datain_o = datain_q;
  assign rd_valid_o    = s2_q;
  assign rd_data_o     = fifo_dataout_i;
  assign flush_done_o  = flush_done_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - directed self-checking bench for fifo_access_arbiter
module tb_fifo_access_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] push_req;
  logic [7:0] push_data;
  logic [1:0] push_gnt;
  logic [1:0] pop_req;
  logic [1:0] pop_gnt;
  logic [1:0] rd_valid;
  logic [3:0] rd_data;
  logic       flush;
  logic       flush_done;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [1:0] fifo_mode;
  logic [3:0] fifo_datain;
  logic [3:0] fifo_dataout;

  int errors = 0;
  int checks = 0;

  logic [3:0] fifo_model[$];
  logic [1:0] exp_gnt[5];
  logic [1:0] exp_mode[4];
  logic [2:0] exp_cnt[4];

  fifo_access_arbiter #(.NREQ(2), .DW(4), .DEPTH(5)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .push_req_i     (push_req),
    .push_data_i    (push_data),
    .push_gnt_o     (push_gnt),
    .pop_req_i      (pop_req),
    .pop_gnt_o      (pop_gnt),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .flush_i        (flush),
    .flush_done_o   (flush_done),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .fifo_mode_o    (fifo_mode),
    .fifo_datain_o  (fifo_datain),
    .fifo_dataout_i (fifo_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: write on 01, registered read on 10.
  initial fifo_dataout = '0;
  always @(posedge clk) begin
    if (fifo_mode == 2'b01) fifo_model.push_back(fifo_datain);
    else if (fifo_mode == 2'b10 && fifo_model.size() > 0) fifo_dataout <= fifo_model.pop_front();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    push_req = '0;
    pop_req  = '0;
    flush    = 1'b0;
    nxt();
    fifo_model.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    exp_mode = '{2'b00, 2'b10, 2'b10, 2'b10};
    exp_cnt  = '{3'd3, 3'd2, 3'd1, 3'd0};
    rst_n     = 1'b0;
    push_req  = '0;
    push_data = '0;
    pop_req   = '0;
    flush     = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    smp();
    check("rst_count", count, 0);
    check("rst_mode", fifo_mode, 0);
    check("rst_datain", fifo_datain, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    nxt();

    // single push; pop at empty must not be granted
    push_req = 2'b01; push_data = 8'h0A; pop_req = 2'b10;
    smp();
    check("t1_push_gnt", push_gnt, 2'b01);
    check("t1_pop_gnt_empty", pop_gnt, 2'b00);
    nxt();
    push_req = '0; pop_req = '0;
    smp();
    check("t1_mode", fifo_mode, 2'b01);
    check("t1_datain", fifo_datain, 4'hA);
    check("t1_count", count, 1);
    nxt();
    do_reset();

    // push then pop, delivery two cycles after the pop grant
    push_req = 2'b10; push_data = 8'h30;
    smp();
    check("t2_push_gnt", push_gnt, 2'b10);
    nxt();
    push_req = '0; pop_req = 2'b10;
    smp();
    check("t2_pop_gnt", pop_gnt, 2'b10);
    check("t2_count1", count, 1);
    nxt();
    pop_req = '0;
    smp();
    check("t2_mode_pop", fifo_mode, 2'b10);
    check("t2_count0", count, 0);
    check("t2_rd_valid_early", rd_valid, 0);
    nxt();
    smp();
    check("t2_rd_valid", rd_valid, 2'b10);
    check("t2_rd_data", rd_data, 4'h3);
    check("t2_empty", empty, 1);
    nxt();

    // fill to full with both producers
    push_req = 2'b11; push_data = 8'h21;
    for (int i = 0; i < 5; i++) begin
      smp();
      check($sformatf("t3_gnt%0d", i), push_gnt, exp_gnt[i]);
      check($sformatf("t3_cnt%0d", i), count, i);
      nxt();
    end
    smp();
    check("t3_gnt_full", push_gnt, 2'b00);
    check("t3_count5", count, 5);
    check("t3_full", full, 1);
    nxt();
    push_req = '0;

    // drain three entries to reach count 2
    pop_req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      smp();
      check($sformatf("t3_pop_gnt%0d", i), pop_gnt, 2'b01);
      check($sformatf("t3_pop_cnt%0d", i), count, 5 - i);
      if (i == 2) begin
        check("t3_rd_valid", rd_valid, 2'b01);
        check("t3_rd_data", rd_data, 4'h1);
      end
      nxt();
    end

    // push and pop contend: classes alternate
    push_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      smp();
      check($sformatf("t4_push_gnt%0d", i), push_gnt, (i % 2 == 0) ? 2'b01 : 2'b00);
      check($sformatf("t4_pop_gnt%0d", i), pop_gnt, (i % 2 == 0) ? 2'b00 : 2'b01);
      check($sformatf("t4_cnt%0d", i), count, (i % 2 == 0) ? 2 : 3);
      nxt();
    end
    pop_req = '0;
    smp();
    check("t4_push_extra", push_gnt, 2'b01);
    check("t4_cnt_after", count, 2);
    nxt();
    push_req = '0;
    repeat (3) nxt();
    smp();
    check("t5_pre_count", count, 3);
    nxt();

    // flush with count 3 while requests are held
    flush = 1'b1; push_req = 2'b01; pop_req = 2'b10;
    smp();
    check("t5_flush_gnt", {push_gnt, pop_gnt}, 4'b0000);
    nxt();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      check($sformatf("t5_mode%0d", i), fifo_mode, exp_mode[i]);
      check($sformatf("t5_cnt%0d", i), count, exp_cnt[i]);
      check($sformatf("t5_gnt%0d", i), {push_gnt, pop_gnt}, 4'b0000);
      check($sformatf("t5_rdv%0d", i), rd_valid, 0);
      check($sformatf("t5_done%0d", i), flush_done, 0);
      nxt();
    end
    smp();
    check("t5_done", flush_done, 1);
    check("t5_mode_idle", fifo_mode, 2'b00);
    check("t5_push_after", push_gnt, 2'b01);
    check("t5_pop_after_empty", pop_gnt, 2'b00);
    nxt();
    push_req = '0;
    smp();
    check("t5_done_pulse", flush_done, 0);
    check("t5_pop_after", pop_gnt, 2'b10);
    check("t5_count1", count, 1);
    nxt();
    pop_req = '0;
    smp();
    nxt();
    smp();
    check("t5_rd_valid", rd_valid, 2'b10);
    check("t5_rd_data", rd_data, 4'h1);
    nxt();

    // reset right after a pop grant kills its delivery
    do_reset();
    push_req = 2'b01; push_data = 8'h05;
    smp();
    check("t6_push_gnt", push_gnt, 2'b01);
    nxt();
    push_req = '0; pop_req = 2'b01;
    smp();
    check("t6_pop_gnt", pop_gnt, 2'b01);
    nxt();
    pop_req = '0; rst_n = 1'b0;
    smp();
    nxt();
    rst_n = 1'b1;
    smp();
    check("t6_rd_valid", rd_valid, 0);
    check("t6_count", count, 0);
    check("t6_mode", fifo_mode, 2'b00);
    nxt();
    smp();
    check("t6_rd_valid_late", rd_valid, 0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
